// File: rtl/cache_trace_generator.sv
// cache_trace_generator: line-aligned address stream source for cache runs; TRACE_STATS_EN adds hit/miss deltas
module cache_trace_generator #(
  parameter int ADDR_W    = 31,
  parameter int LINE_SIZE = 32,
  parameter int CNT_W     = 31
) (
  input  logic              Clock_10,
  input  logic              Reset_10,
  input  logic              Start_10,
  input  logic [1:0]        Mode_10,
  input  logic [ADDR_W-1:0] Base_10,
  input  logic [ADDR_W-1:0] Stride_10,
  input  logic [CNT_W-1:0]  WorkSet_10,
  input  logic [ADDR_W-1:0] Seed_10,
  input  logic [CNT_W-1:0]  Length_10,
  input  logic              AddrReady_10,
`ifdef TRACE_STATS_EN
  input  logic [30:0]       HitIn_10,
  input  logic [30:0]       MissIn_10,
  output logic [30:0]       RunHits_10,
  output logic [30:0]       RunMisses_10,
`endif
  output logic [ADDR_W-1:0] Address_10,
  output logic              AddrValid_10,
  output logic              Busy_10,
  output logic              Done_10,
  output logic [CNT_W-1:0]  Issued_10
);
  localparam int O = $clog2(LINE_SIZE);
  localparam logic [ADDR_W-1:0] MASK = ~ADDR_W'(LINE_SIZE - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, base_q, base_d, stride_q, stride_d, next_addr;
  logic              valid_q, valid_d, xfer;
  logic [CNT_W-1:0]  issued_q, issued_d, issued_inc, len_q, len_d, ws_q, ws_d, off_q, off_d, off_nx;
  logic [1:0]        mode_q, mode_d;
  logic [30:0]       lfsr_q, lfsr_d, lfsr_nx, seed;
  assign Address_10   = addr_q;
  assign AddrValid_10 = valid_q;
  assign Busy_10      = state_q == RUN;
  assign Done_10      = state_q == DONE;
  assign Issued_10    = issued_q;
  // state and run-context registers; reset aborts any run in progress
  always_ff @(posedge Clock_10) begin
    if (Reset_10) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      valid_q  <= 1'b0;
      issued_q <= '0;
      lfsr_q   <= 31'd1;
      off_q    <= '0;
      mode_q   <= '0;
      base_q   <= '0;
      stride_q <= '0;
      ws_q     <= CNT_W'(1);
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      issued_q <= issued_d;
      lfsr_q   <= lfsr_d;
      off_q    <= off_d;
      mode_q   <= mode_d;
      base_q   <= base_d;
      stride_q <= stride_d;
      ws_q     <= ws_d;
      len_q    <= len_d;
    end
  end
  // launch latching, handshake progress and next-address generation per mode
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    valid_d    = valid_q;
    issued_d   = issued_q;
    lfsr_d     = lfsr_q;
    off_d      = off_q;
    mode_d     = mode_q;
    base_d     = base_q;
    stride_d   = stride_q;
    ws_d       = ws_q;
    len_d      = len_q;
    xfer       = valid_q & AddrReady_10;
    issued_inc = issued_q + CNT_W'(1);
    off_nx     = (off_q == ws_q - CNT_W'(1)) ? '0 : off_q + CNT_W'(1);
    lfsr_nx    = {lfsr_q[29:0], lfsr_q[30] ^ lfsr_q[27]};
    seed       = (31'(Seed_10) == '0) ? 31'd1 : 31'(Seed_10);
    next_addr  = (mode_q == 2'd0) ? addr_q + ADDR_W'(LINE_SIZE) :
                 (mode_q == 2'd1) ? addr_q + stride_q :
                 (mode_q == 2'd2) ? ADDR_W'(lfsr_nx) & MASK :
                                    base_q + (ADDR_W'(off_nx) << O);
    case (state_q)
      IDLE: if (Start_10) begin
        mode_d   = Mode_10;
        base_d   = Base_10 & MASK;
        stride_d = Stride_10 & MASK;
        ws_d     = (WorkSet_10 == '0) ? CNT_W'(1) : WorkSet_10;
        len_d    = Length_10;
        lfsr_d   = seed;
        off_d    = '0;
        issued_d = '0;
        state_d  = (Length_10 == '0) ? DONE : RUN;
        valid_d  = Length_10 != '0;
        addr_d   = (Mode_10 == 2'd2) ? ADDR_W'(seed) & MASK : Base_10 & MASK;
      end
      RUN: if (xfer) begin
        issued_d = issued_inc;
        lfsr_d   = lfsr_nx;
        off_d    = off_nx;
        state_d  = (issued_inc == len_q) ? DONE : RUN;
        valid_d  = issued_inc != len_q;
        addr_d   = (issued_inc == len_q) ? addr_q : next_addr;
      end
      default: state_d = IDLE;
    endcase
  end
`ifdef TRACE_STATS_EN
  logic [30:0] hit_snap_q, miss_snap_q, run_hits_q, run_miss_q;
  assign RunHits_10   = run_hits_q;
  assign RunMisses_10 = run_miss_q;
  // counter snapshot at launch, per-run delta captured on the DONE cycle
  always_ff @(posedge Clock_10) begin
    if (Reset_10) begin
      hit_snap_q  <= '0;
      miss_snap_q <= '0;
      run_hits_q  <= '0;
      run_miss_q  <= '0;
    end else begin
      if (state_q == IDLE && Start_10) begin
        hit_snap_q  <= HitIn_10;
        miss_snap_q <= MissIn_10;
      end
      if (state_q == DONE) begin
        run_hits_q <= HitIn_10 - hit_snap_q;
        run_miss_q <= MissIn_10 - miss_snap_q;
      end
    end
  end
`endif
endmodule

// File: tb/tb_cache_trace_generator.sv
// tb_cache_trace_generator: directed checks of address patterns, handshake, length-0, reset abort and wrap
module tb_cache_trace_generator;
  logic        clk = 1'b0, rst;
  logic        start, ready;
  logic [1:0]  mode;
  logic [30:0] base, stride, ws, seed, len, addr, issued;
  logic        valid, busy, done;
`ifdef TRACE_STATS_EN
  logic [30:0] hit_in, miss_in, run_hits, run_miss;
`endif
  int checks = 0, errors = 0;
  logic [30:0] l;
  cache_trace_generator dut (
    .Clock_10(clk), .Reset_10(rst), .Start_10(start), .Mode_10(mode), .Base_10(base),
    .Stride_10(stride), .WorkSet_10(ws), .Seed_10(seed), .Length_10(len), .AddrReady_10(ready),
`ifdef TRACE_STATS_EN
    .HitIn_10(hit_in), .MissIn_10(miss_in), .RunHits_10(run_hits), .RunMisses_10(run_miss),
`endif
    .Address_10(addr), .AddrValid_10(valid), .Busy_10(busy), .Done_10(done), .Issued_10(issued)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic launch(input logic [1:0] m, input logic [30:0] b, input logic [30:0] s,
                        input logic [30:0] w, input logic [30:0] sd, input logic [30:0] n);
    mode = m; base = b; stride = s; ws = w; seed = sd; len = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; ready = 1'b1; mode = '0; base = '0; stride = '0; ws = '0; seed = '0; len = '0;
`ifdef TRACE_STATS_EN
    hit_in = '0; miss_in = '0;
`endif
    tick(); tick();
    rst = 1'b0;
    chk("rst_addr", addr, 0); chk("rst_valid", valid, 0); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0); chk("rst_issued", issued, 0);
    launch(2'd0, 31'h40, 31'h0, 31'h0, 31'h0, 31'd4);
    for (int i = 0; i < 4; i++) begin
      chk("seq_addr", addr, 64'h40 + 64'h20 * i); chk("seq_valid", valid, 1); chk("seq_busy", busy, 1);
      tick();
    end
    chk("seq_done", done, 1); chk("seq_valid_end", valid, 0); chk("seq_busy_end", busy, 0);
    chk("seq_issued", issued, 4);
    tick();
    chk("seq_done_pulse", done, 0);
    launch(2'd1, 31'h1F, 31'h100, 31'h0, 31'h0, 31'd3);
    chk("str_a0", addr, 31'h0);
    tick();
    chk("str_a1", addr, 31'h100);
    ready = 1'b0;
    tick();
    chk("str_hold_addr", addr, 31'h100); chk("str_hold_valid", valid, 1); chk("str_hold_issued", issued, 1);
    ready = 1'b1;
    tick();
    chk("str_a2", addr, 31'h200); chk("str_issued2", issued, 2);
    tick();
    chk("str_done", done, 1); chk("str_issued", issued, 3);
    tick();
    launch(2'd3, 31'h1000, 31'h0, 31'd2, 31'h0, 31'd5);
    base = 31'hDEAD0;
    for (int i = 0; i < 5; i++) begin
      chk("ws_addr", addr, (i % 2) ? 64'h1020 : 64'h1000);
      tick();
    end
    chk("ws_done", done, 1); chk("ws_issued", issued, 5);
    tick();
    launch(2'd2, 31'h0, 31'h0, 31'h0, 31'h0, 31'd8);
    for (int i = 0; i < 8; i++) begin
      chk("lfsr0_addr", addr, (i < 5) ? 64'h0 : (64'h20 << (i - 5)));
      tick();
    end
    chk("lfsr0_done", done, 1);
    tick();
    l = 31'h12345678;
    launch(2'd2, 31'h0, 31'h0, 31'h0, 31'h12345678, 31'd6);
    for (int i = 0; i < 6; i++) begin
      chk("lfsr_addr", addr, l & ~31'h1F);
      l = {l[29:0], l[30] ^ l[27]};
      tick();
    end
    chk("lfsr_done", done, 1);
    tick();
    launch(2'd0, 31'h80, 31'h0, 31'h0, 31'h0, 31'd0);
    chk("len0_valid", valid, 0); chk("len0_done", done, 1); chk("len0_busy", busy, 0);
    tick();
    chk("len0_done_pulse", done, 0); chk("len0_valid_after", valid, 0);
    launch(2'd0, 31'h200, 31'h0, 31'h0, 31'h0, 31'd10);
    tick();
    chk("abort_pre_addr", addr, 31'h220);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_addr", addr, 0); chk("abort_valid", valid, 0); chk("abort_busy", busy, 0);
    chk("abort_done", done, 0); chk("abort_issued", issued, 0);
    tick();
    chk("abort_no_valid", valid, 0);
`ifdef TRACE_STATS_EN
    hit_in = 31'd5; miss_in = 31'd3;
`endif
    launch(2'd0, 31'h7FFFFFE0, 31'h0, 31'h0, 31'h0, 31'd2);
    chk("wrap_a0", addr, 31'h7FFFFFE0);
`ifdef TRACE_STATS_EN
    hit_in = 31'd7;
`endif
    tick();
    chk("wrap_a1", addr, 31'h0);
    tick();
    chk("wrap_done", done, 1); chk("wrap_issued", issued, 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_start_ignored_valid", valid, 0); chk("done_start_ignored_busy", busy, 0);
`ifdef TRACE_STATS_EN
    chk("run_hits", run_hits, 2); chk("run_misses", run_miss, 0);
`endif
    tick();
    chk("idle_stays", valid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
